// File: rtl/inst_mem_fetch_pkg.sv
// Shared definitions for the IF-stage instruction memory: boot FSM states,
// the default NOP word and RISC-V major opcodes used by benches and decoders.
package inst_mem_fetch_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;

    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/inst_mem_fetch_ram.sv
// Byte-organised instruction storage: one 8-bit bank per byte lane, so a
// word-aligned access touches M[a..a+3] in a single cycle; read is combinational.
module imem_byte_ram #(
    parameter int DEPTH_BYTES = 256
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [$clog2(DEPTH_BYTES)-3:0] wr_widx,
    input  logic [31:0]                   wr_data,
    input  logic [$clog2(DEPTH_BYTES)-3:0] rd_widx,
    output logic [31:0]                   rd_data
);

    localparam int WORDS = DEPTH_BYTES / 4;

    // Lane gi holds byte address 4*w+gi, giving little-endian word layout.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] bank [WORDS];

        always_ff @(posedge clk) begin
            if (wr_en) begin
                bank[wr_widx] <= wr_data[8*gi +: 8];
            end
        end

        assign rd_data[8*gi +: 8] = bank[rd_widx];
    end

endmodule

// File: rtl/inst_mem_fetch.sv
// IF-stage instruction memory: LOAD->RUN boot FSM, word load port with sticky
// error, and a registered 1-cycle fetch with stall/flush and fault reporting.
module inst_mem_fetch
    import inst_mem_fetch_pkg::*;
#(
    parameter int          DEPTH_BYTES = 256,
    parameter int          ADDR_W      = 64,
    parameter logic [31:0] NOP_INSTR   = NOP_INSTR_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              Load_En,
    input  logic [ADDR_W-1:0] Load_Addr,
    input  logic [31:0]       Load_Data,
    input  logic              Load_Done,
    input  logic              Fetch_Req,
    input  logic [ADDR_W-1:0] Inst_Address,
    input  logic              Stall,
    input  logic              Flush,
    output logic              Fetch_Ready,
    output logic              Inst_Valid,
    output logic [31:0]       Instruction,
    output logic              Inst_Fault,
    output logic              Load_Err
);

    localparam int                IDX_W          = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_W-1:0] LAST_WORD_ADDR = ADDR_W'(DEPTH_BYTES - 4);

    fetch_state_e state_reg, state_next;
    logic         valid_reg, valid_next;
    logic [31:0]  instr_reg, instr_next;
    logic         fault_reg, fault_next;
    logic         load_err_reg, load_err_next;

    logic         accept;
    logic         fetch_bad;
    logic         load_bad_addr;
    logic         load_wr;
    logic [31:0]  ram_rdata;

    // Full-width compares: a huge PC must not alias into the array.
    assign fetch_bad     = (Inst_Address[1:0] != 2'b00) || (Inst_Address > LAST_WORD_ADDR);
    assign load_bad_addr = (Load_Addr[1:0] != 2'b00) || (Load_Addr > LAST_WORD_ADDR);

    assign load_wr     = Load_En && (state_reg == ST_LOAD) && !load_bad_addr;
    assign Fetch_Ready = (state_reg == ST_RUN) && !Stall;
    assign accept      = Fetch_Req && Fetch_Ready;

    imem_byte_ram #(
        .DEPTH_BYTES(DEPTH_BYTES)
    ) u_ram (
        .clk    (clk),
        .wr_en  (load_wr),
        .wr_widx(Load_Addr[IDX_W-1:2]),
        .wr_data(Load_Data),
        .rd_widx(Inst_Address[IDX_W-1:2]),
        .rd_data(ram_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_LOAD;
            valid_reg    <= 1'b0;
            instr_reg    <= NOP_INSTR;
            fault_reg    <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            valid_reg    <= valid_next;
            instr_reg    <= instr_next;
            fault_reg    <= fault_next;
            load_err_reg <= load_err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        valid_next    = 1'b0;
        instr_next    = instr_reg;
        fault_next    = 1'b0;
        load_err_next = load_err_reg;

        case (state_reg)
            ST_LOAD: if (Load_Done) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_LOAD;
        endcase

        if (Load_En && !load_wr) begin
            load_err_next = 1'b1;
        end

        // An accept alongside Flush is the branch target, so it wins over the kill.
        if (accept) begin
            valid_next = 1'b1;
            instr_next = fetch_bad ? NOP_INSTR : ram_rdata;
            fault_next = fetch_bad;
        end else if (Flush) begin
            instr_next = NOP_INSTR;
        end else if (Stall) begin
            valid_next = valid_reg;
            fault_next = fault_reg;
        end
    end

    assign Inst_Valid  = valid_reg;
    assign Instruction = instr_reg;
    assign Inst_Fault  = fault_reg;
    assign Load_Err    = load_err_reg;

endmodule

// File: tb/tb_inst_mem_fetch.sv
// Directed bench for inst_mem_fetch: load/run boot, back-to-back fetch,
// faults, stall, flush and asynchronous reset with memory retention.
module tb_inst_mem_fetch;

    localparam int DEPTH_BYTES = 256;
    localparam int ADDR_W      = 64;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              Load_En;
    logic [ADDR_W-1:0] Load_Addr;
    logic [31:0]       Load_Data;
    logic              Load_Done;
    logic              Fetch_Req;
    logic [ADDR_W-1:0] Inst_Address;
    logic              Stall;
    logic              Flush;
    logic              Fetch_Ready;
    logic              Inst_Valid;
    logic [31:0]       Instruction;
    logic              Inst_Fault;
    logic              Load_Err;

    int checks = 0;
    int errors = 0;

    inst_mem_fetch #(
        .DEPTH_BYTES(DEPTH_BYTES),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .Load_En     (Load_En),
        .Load_Addr   (Load_Addr),
        .Load_Data   (Load_Data),
        .Load_Done   (Load_Done),
        .Fetch_Req   (Fetch_Req),
        .Inst_Address(Inst_Address),
        .Stall       (Stall),
        .Flush       (Flush),
        .Fetch_Ready (Fetch_Ready),
        .Inst_Valid  (Inst_Valid),
        .Instruction (Instruction),
        .Inst_Fault  (Inst_Fault),
        .Load_Err    (Load_Err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
        Load_En   = 1'b1;
        Load_Addr = addr;
        Load_Data = data;
        tick();
        Load_En   = 1'b0;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] addr);
        Fetch_Req    = 1'b1;
        Inst_Address = addr;
        tick();
        Fetch_Req    = 1'b0;
    endtask

    task automatic check_resp(input string tag, input logic v, input logic [31:0] ins, input logic f);
        check_val({tag, ".valid"}, 64'(Inst_Valid), 64'(v));
        check_val({tag, ".instr"}, 64'(Instruction), 64'(ins));
        check_val({tag, ".fault"}, 64'(Inst_Fault), 64'(f));
    endtask

    initial begin
        reset_n = 1'b1; Load_En = 1'b0; Load_Addr = '0; Load_Data = '0; Load_Done = 1'b0;
        Fetch_Req = 1'b0; Inst_Address = '0; Stall = 1'b0; Flush = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        check_resp("reset", 1'b0, NOP, 1'b0);
        check_val("reset.ready", 64'(Fetch_Ready), 64'd0);
        check_val("reset.load_err", 64'(Load_Err), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Fetch while still loading is refused
        Fetch_Req = 1'b1; Inst_Address = '0;
        #1 check_val("load.ready", 64'(Fetch_Ready), 64'd0);
        tick();
        check_val("load.valid", 64'(Inst_Valid), 64'd0);
        Fetch_Req = 1'b0;

        load_word(64'd0, 32'h0040_0193);
        load_word(64'd4, 32'h0031_8193);
        // Last word written in the same cycle as Load_Done
        Load_Done = 1'b1;
        load_word(64'd8, 32'h0030_0233);
        Load_Done = 1'b0;
        check_val("run.ready", 64'(Fetch_Ready), 64'd1);

        // Back-to-back fetches, one response per edge
        Fetch_Req = 1'b1;
        Inst_Address = 64'd0; tick(); check_resp("b2b0", 1'b1, 32'h0040_0193, 1'b0);
        Inst_Address = 64'd4; tick(); check_resp("b2b4", 1'b1, 32'h0031_8193, 1'b0);
        Inst_Address = 64'd8; tick(); check_resp("b2b8", 1'b1, 32'h0030_0233, 1'b0);
        Fetch_Req = 1'b0;
        tick();
        check_resp("idle", 1'b0, 32'h0030_0233, 1'b0);

        // Faults: misaligned, first out-of-range word, huge address
        fetch(64'd2);   check_resp("mis2", 1'b1, NOP, 1'b0 | 1'b1);
        fetch(64'd256); check_resp("oor256", 1'b1, NOP, 1'b1);
        fetch(64'h8000_0000_0000_0000); check_resp("oorbig", 1'b1, NOP, 1'b1);
        fetch(64'd252); check_val("edge252.fault", 64'(Inst_Fault), 64'd0);

        // Load in RUN is refused and flagged
        load_word(64'd0, 32'hFFFF_FFFF);
        check_val("run_load.err", 64'(Load_Err), 64'd1);
        fetch(64'd0); check_resp("run_load.mem", 1'b1, 32'h0040_0193, 1'b0);

        // Stall holds the response and blocks the next request
        fetch(64'd4);
        Stall = 1'b1; Fetch_Req = 1'b1; Inst_Address = 64'd8;
        #1 check_val("stall.ready", 64'(Fetch_Ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_resp($sformatf("stall%0d", i), 1'b1, 32'h0031_8193, 1'b0);
        end
        Stall = 1'b0;
        tick();
        check_resp("unstall", 1'b1, 32'h0030_0233, 1'b0);
        Fetch_Req = 1'b0;

        // Flush with a branch-target fetch in the same cycle
        fetch(64'd0);
        Flush = 1'b1;
        fetch(64'd8);
        check_resp("flush_tgt", 1'b1, 32'h0030_0233, 1'b0);
        tick();
        check_resp("flush_only", 1'b0, NOP, 1'b0);
        Flush = 1'b0;

        // Flush beats Stall, including a held fault
        fetch(64'd6);
        Stall = 1'b1; Flush = 1'b1;
        tick();
        check_resp("flush_stall", 1'b0, NOP, 1'b0);
        Stall = 1'b0; Flush = 1'b0;

        // Async reset mid-stream
        Fetch_Req = 1'b1; Inst_Address = 64'd4;
        tick();
        #2 reset_n = 1'b0;
        #1;
        check_resp("arst", 1'b0, NOP, 1'b0);
        check_val("arst.ready", 64'(Fetch_Ready), 64'd0);
        check_val("arst.load_err", 64'(Load_Err), 64'd0);
        Fetch_Req = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        // Misaligned load flags an error and leaves memory alone
        load_word(64'd2, 32'hDEAD_BEEF);
        check_val("mis_load.err", 64'(Load_Err), 64'd1);
        Load_Done = 1'b1; tick(); Load_Done = 1'b0;
        fetch(64'd0); check_resp("retain0", 1'b1, 32'h0040_0193, 1'b0);
        fetch(64'd4); check_resp("retain4", 1'b1, 32'h0031_8193, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
